// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - UART-style receive framer with stop-bit check, strobe-gap timeout and 4-deep FWFT byte FIFO.
// Sticky error flags; head-of-queue byte is always presented on rx_data.

module rx_frame_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [2:0] count
);
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic       wr_en;

  // A full queue still accepts a byte when the head leaves in the same cycle.
  assign wr_en = push && ((count_q != 3'd4) || pop);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, wr_en} - {2'b00, pop};
    end
  end
endmodule

module rx_frame_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk_8mhz,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic       out_bit,
  input  logic       valid_now,
  input  logic       byte_start,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [2:0] fifo_count,
  output logic       err_framing,
  output logic       err_overrun,
  output logic       err_timeout,
  input  logic       err_clear,
  output logic       busy
);
  localparam int GW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t      state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [GW-1:0] gap_q;
  logic        busy_q;
  logic        err_framing_q, err_framing_d;
  logic        err_overrun_q, err_overrun_d;
  logic        err_timeout_q, err_timeout_d;

  logic       in_frame;
  logic       restart;
  logic       stop_ok;
  logic       stop_bad;
  logic       gap_expired;
  logic       pop;
  logic       overrun;

  assign in_frame    = (state_q != IDLE);
  assign restart     = rx_en && in_frame && byte_start;
  assign stop_ok     = rx_en && (state_q == STOP) && !byte_start && valid_now && out_bit;
  assign stop_bad    = rx_en && (state_q == STOP) && !byte_start && valid_now && !out_bit;
  assign gap_expired = rx_en && in_frame && !byte_start && !valid_now &&
                       (gap_q == GW'(TIMEOUT_CYC - 1));
  assign pop         = rx_valid && rx_ready;
  assign overrun     = stop_ok && (fifo_count == 3'd4) && !pop;

  rx_frame_fifo u_fifo (
    .clk       (clk_8mhz),
    .rst_n     (rst_n),
    .push      (stop_ok),
    .push_data (shift_q),
    .pop       (pop),
    .head      (rx_data),
    .count     (fifo_count)
  );

  assign rx_valid = (fifo_count != 3'd0);

  always_ff @(posedge clk_8mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      gap_q     <= '0;
      busy_q    <= 1'b0;
    end else if (!rx_en) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      gap_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (byte_start) begin
            state_q   <= DATA;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            gap_q     <= '0;
            busy_q    <= 1'b1;
          end
        end
        DATA, STOP: begin
          if (byte_start) begin
            state_q   <= DATA;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            gap_q     <= '0;
            busy_q    <= 1'b1;
          end else if (valid_now) begin
            gap_q <= '0;
            if (state_q == DATA) begin
              shift_q[bit_cnt_q] <= out_bit;
              bit_cnt_q          <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= STOP;
            end else begin
              state_q   <= IDLE;
              bit_cnt_q <= 3'd0;
              busy_q    <= 1'b0;
            end
          end else if (gap_expired) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            gap_q     <= '0;
            busy_q    <= 1'b0;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          bit_cnt_q <= 3'd0;
          gap_q     <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // A new error event in the same cycle as err_clear must survive.
  always_comb begin
    err_framing_d = (restart || stop_bad) || (err_framing_q && !err_clear);
    err_overrun_d = overrun || (err_overrun_q && !err_clear);
    err_timeout_d = gap_expired || (err_timeout_q && !err_clear);
  end

  always_ff @(posedge clk_8mhz or negedge rst_n) begin
    if (!rst_n) begin
      err_framing_q <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_framing_q <= err_framing_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_framing = err_framing_q;
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - directed self-checking bench for rx_frame_ctrl.
// Inputs change 1ns after each rising edge; outputs are checked there too.

module tb_rx_frame_ctrl;
  logic       clk_8mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b1;
  logic       out_bit = 1'b0;
  logic       valid_now = 1'b0;
  logic       byte_start = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [2:0] fifo_count;
  logic       err_framing;
  logic       err_overrun;
  logic       err_timeout;
  logic       err_clear = 1'b0;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  rx_frame_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk_8mhz    (clk_8mhz),
    .rst_n       (rst_n),
    .rx_en       (rx_en),
    .out_bit     (out_bit),
    .valid_now   (valid_now),
    .byte_start  (byte_start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .fifo_count  (fifo_count),
    .err_framing (err_framing),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout),
    .err_clear   (err_clear),
    .busy        (busy)
  );

  always #5 clk_8mhz = ~clk_8mhz;

  task automatic tick();
    @(posedge clk_8mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".rx_data"},  {24'd0, rx_data}, 32'h00);
    check({tag, ".rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, ".count"},    {29'd0, fifo_count}, 32'd0);
    check({tag, ".errs"},     {29'd0, err_framing, err_overrun, err_timeout}, 32'd0);
    check({tag, ".busy"},     {31'd0, busy}, 32'd0);
  endtask

  task automatic strobe(input logic b);
    valid_now = 1'b1;
    out_bit   = b;
    tick();
    valid_now = 1'b0;
    out_bit   = 1'b0;
  endtask

  task automatic start();
    byte_start = 1'b1;
    tick();
    byte_start = 1'b0;
  endtask

  // pop_on_stop raises rx_ready only across the stop-bit edge.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic pop_on_stop);
    start();
    for (int i = 0; i < 8; i++) strobe(data[i]);
    rx_ready = pop_on_stop;
    strobe(stop);
    rx_ready = 1'b0;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check_reset_state("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single good frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5.data",  {24'd0, rx_data}, 32'hA5);
    check("a5.valid", {31'd0, rx_valid}, 32'd1);
    check("a5.count", {29'd0, fifo_count}, 32'd1);
    check("a5.busy",  {31'd0, busy}, 32'd0);

    // Second frame 0xE1 queued behind 0xA5, head held
    send_frame(8'hE1, 1'b1, 1'b0);
    check("e1.count", {29'd0, fifo_count}, 32'd2);
    check("e1.head",  {24'd0, rx_data}, 32'hA5);
    pop_one();
    check("pop1.data",  {24'd0, rx_data}, 32'hE1);
    check("pop1.count", {29'd0, fifo_count}, 32'd1);
    pop_one();
    check("pop2.valid", {31'd0, rx_valid}, 32'd0);

    // Bad stop bit
    send_frame(8'hA5, 1'b0, 1'b0);
    check("badstop.framing", {31'd0, err_framing}, 32'd1);
    check("badstop.count",   {29'd0, fifo_count}, 32'd0);
    pulse_clear();
    check("clear.framing", {31'd0, err_framing}, 32'd0);

    // Overrun: five frames, nothing consumed
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("ovr.count",   {29'd0, fifo_count}, 32'd4);
    check("ovr.flag",    {31'd0, err_overrun}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr.pop%0d", i), {24'd0, rx_data}, 32'(i));
      pop_one();
    end
    check("ovr.empty", {31'd0, rx_valid}, 32'd0);
    pulse_clear();
    check("ovr.cleared", {31'd0, err_overrun}, 32'd0);

    // Full FIFO with a pop on the 5th push: accepted, pointers wrap
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    send_frame(8'h05, 1'b1, 1'b1);
    check("fullpop.count", {29'd0, fifo_count}, 32'd4);
    check("fullpop.ovr",   {31'd0, err_overrun}, 32'd0);
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("fullpop.pop%0d", i), {24'd0, rx_data}, 32'(i));
      pop_one();
    end
    check("fullpop.empty", {31'd0, rx_valid}, 32'd0);

    // Timeout after three data strobes
    start();
    strobe(1'b1); strobe(1'b0); strobe(1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("tmo.busy15", {31'd0, busy}, 32'd1);
    check("tmo.flag15", {31'd0, err_timeout}, 32'd0);
    tick();
    check("tmo.busy16", {31'd0, busy}, 32'd0);
    check("tmo.flag16", {31'd0, err_timeout}, 32'd1);
    check("tmo.count",  {29'd0, fifo_count}, 32'd0);
    pulse_clear();
    check("tmo.cleared", {31'd0, err_timeout}, 32'd0);

    // byte_start mid-frame restarts and flags framing
    start();
    strobe(1'b1); strobe(1'b1); strobe(1'b1);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("restart.framing", {31'd0, err_framing}, 32'd1);
    check("restart.data",    {24'd0, rx_data}, 32'h3C);
    check("restart.count",   {29'd0, fifo_count}, 32'd1);
    pop_one();
    pulse_clear();

    // rx_en low mid-frame: silent abort
    start();
    strobe(1'b0); strobe(1'b1); strobe(1'b0); strobe(1'b1);
    rx_en = 1'b0;
    tick();
    check("rxen.busy", {31'd0, busy}, 32'd0);
    check("rxen.errs", {29'd0, err_framing, err_overrun, err_timeout}, 32'd0);
    strobe(1'b1); strobe(1'b1); strobe(1'b1); strobe(1'b1); strobe(1'b1);
    check("rxen.count", {29'd0, fifo_count}, 32'd0);
    rx_en = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0);
    check("rxen.data", {24'd0, rx_data}, 32'h5A);

    // Reset during data bit 4 with FIFO occupied and a sticky error set
    start();
    strobe(1'b1); strobe(1'b1);
    byte_start = 1'b1;
    tick();
    byte_start = 1'b0;
    check("prerst.framing", {31'd0, err_framing}, 32'd1);
    strobe(1'b1); strobe(1'b0); strobe(1'b0); strobe(1'b0);
    valid_now = 1'b1;
    out_bit   = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_reset_state("midrst");
    tick();
    valid_now = 1'b0;
    rst_n     = 1'b1;
    check_reset_state("postrst");
    strobe(1'b0); strobe(1'b1); strobe(1'b1); strobe(1'b1);
    check("postrst.idle", {31'd0, busy}, 32'd0);
    send_frame(8'hE1, 1'b1, 1'b0);
    check("postrst.data",  {24'd0, rx_data}, 32'hE1);
    check("postrst.count", {29'd0, fifo_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 The block SHALL have the parameter TIMEOUT_CYC, default 16, meaning the clk_8mhz cycles allowed between bit strobes before a frame is aborted (two bit periods at 8 clk/bit).
REQ-002 The block SHALL have the ports below, one per line: name, direction, width, meaning.
- clk_8mhz  in  1  sole clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_en  in  1  receiver enable; low forces IDLE and ignores inputs.
- out_bit  in  1  recovered bit from rxpath.
- valid_now  in  1  one-cycle strobe; out_bit is valid this cycle.
- byte_start  in  1  one-cycle strobe; start bit detected.
- rx_data  out  8  head-of-FIFO byte.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- fifo_count  out  3  stored bytes, 0..4.
- err_framing  out  1  sticky: bad stop bit or start during a frame.
- err_overrun  out  1  sticky: good byte dropped because FIFO was full.
- err_timeout  out  1  sticky: strobe gap exceeded TIMEOUT_CYC.
- err_clear  in  1  one-cycle pulse; clears all sticky errors.
- busy  out  1  FSM not in IDLE.

Function
REQ-003 FSM states SHALL be IDLE, DATA, STOP; busy=1 in DATA and STOP.
REQ-004 IDLE SHALL ignore valid_now; byte_start with rx_en=1 SHALL move to DATA with bit_cnt=0, shift register cleared, gap counter=0.
REQ-005 In DATA, each valid_now SHALL store out_bit at bit position bit_cnt (LSB first) and increment bit_cnt; the strobe with bit_cnt=7 SHALL move to STOP.
REQ-006 In STOP, valid_now with out_bit=1 SHALL push the assembled byte and return to IDLE; with out_bit=0 it SHALL discard the byte, set err_framing, and return to IDLE.
REQ-007 byte_start in DATA or STOP SHALL set err_framing, discard the partial byte, and restart DATA with bit_cnt=0 in the same cycle.
REQ-008 The gap counter SHALL count cycles in DATA/STOP without valid_now, reset on each valid_now; reaching TIMEOUT_CYC SHALL set err_timeout, discard, and return to IDLE.
REQ-009 rx_en=0 SHALL force IDLE next cycle, discarding any partial byte, with no error flagged; FIFO contents and error flags SHALL be retained.
REQ-010 The FIFO SHALL be 4x8 first-word-fall-through; a pushed byte SHALL appear on rx_data with rx_valid=1 on the cycle after the stop-bit strobe when the FIFO was empty.
REQ-011 A pop SHALL occur when rx_valid && rx_ready; rx_data SHALL be held stable while rx_valid=1 and no pop occurs.
REQ-012 A push with fifo_count=4 and no same-cycle pop SHALL drop the byte and set err_overrun; a push with fifo_count=4 and a same-cycle pop SHALL be accepted, leaving fifo_count at 4.
REQ-013 Simultaneous push and pop at fifo_count=1..3 SHALL leave fifo_count unchanged; pointers SHALL wrap modulo 4.
REQ-014 err_clear SHALL clear all error flags the next cycle; a same-cycle error set SHALL take priority over err_clear.

Reset
REQ-015 rst_n=0 SHALL asynchronously force IDLE, bit_cnt=0, gap counter=0, empty FIFO, rx_valid=0, rx_data=0x00, fifo_count=0, busy=0, and all err_* flags=0.
REQ-016 Reset assertion mid-frame SHALL discard the partial byte; after deassertion the block SHALL wait for a new byte_start.

Verification
REQ-017 byte_start, then data strobes with bits 1,0,1,0,0,1,0,1, then stop=1 -> rx_data=0xA5, rx_valid=1 one cycle after the stop strobe, fifo_count=1.
REQ-018 0xA5 followed by a frame with bits 1,0,0,0,0,1,1,1 and stop=1, rx_ready=0 -> fifo_count=2; pops return 0xA5 then 0xE1; rx_valid=0 after the second pop.
REQ-019 Frame 0xA5 with stop=0 -> no push, err_framing=1, fifo_count unchanged; err_clear pulse -> err_framing=0.
REQ-020 Five good frames 0x01..0x05 with rx_ready=0 -> fifo_count=4, err_overrun=1, pops yield 0x01..0x04; repeat with a pop coinciding with the 5th push -> no overrun.
REQ-021 Three data strobes, then no strobes for 16 cycles -> err_timeout=1, busy=0, no push.
REQ-022 rst_n low for 1 cycle during data bit 4 -> all outputs at reset values; a following complete 0xE1 frame -> rx_data=0xE1.
